return_button_tracker: RTL and testbench
========================================

Name: return_button_tracker

Overview:
- Upstream stage of the game-over screen pixel generator.
- Takes the mouse cursor position in VGA pixel space and the raw left-button level.
- Produces the registered hover flag (`mouse_on_return_button`), a debounced button level (`mouse_left_db`) for CLICK/TOUCH colouring, and a one-cycle `return_click` pulse.
- `return_click` drives the scene FSM back to the menu; it fires only on a genuine click: press inside the button, then release inside it.

Parameters:
- BTN_X0, 256, left edge of button rectangle, inclusive, pixels
- BTN_X1, 383, right edge, inclusive
- BTN_Y0, 352, top edge, inclusive
- BTN_Y1, 399, bottom edge, inclusive
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles required to accept a button level change; legal range 1..2^20-1

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- enable  input  1  high while the game-over scene is displayed
- mouse_x  input  10  cursor column, 0..639
- mouse_y  input  10  cursor row, 0..479
- MOUSE_LEFT  input  1  raw left-button level, already in clk domain
- mouse_on_return_button  output  1  cursor inside rectangle, registered
- mouse_left_db  output  1  debounced left-button level
- return_click  output  1  one-cycle pulse on valid click-release
- btn_state  output  2  current FSM state, for debug/LED

Behaviour:
- One clock (`clk`); all state updates on the rising edge.
- Reset is synchronous and active-high: when `rst` is high at a rising edge, all state and outputs clear on that edge.
- Reset values:
  - `mouse_on_return_button` = 0, `mouse_left_db` = 0, `return_click` = 0.
  - `btn_state` = IDLE (2'd0); debounce counter = 0.
- Hit test:
  - inside = (BTN_X0 ≤ mouse_x ≤ BTN_X1) && (BTN_Y0 ≤ mouse_y ≤ BTN_Y1); unsigned 10-bit compares.
  - Registered; latency 1 cycle.
  - `mouse_on_return_button` = inside && enable.
- Debounce:
  - The counter increments while MOUSE_LEFT != mouse_left_db, and clears to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the mismatch persists, on the next edge: mouse_left_db <= MOUSE_LEFT and counter <= 0.
  - Consequence: a level held for exactly DEBOUNCE_CYCLES cycles is accepted; any glitch shorter than that is ignored.
  - The counter saturates; it never wraps.
  - The debounce runs regardless of `enable`.
- FSM, evaluated on the debounced level and the registered inside flag:
  - IDLE (0):
    - press edge with inside -> ARMED.
    - press edge with !inside -> HELD_OUT.
  - ARMED (1):
    - release with inside -> IDLE, and return_click = 1 for exactly one cycle.
    - !inside while held -> DRAGGED (2).
  - DRAGGED (2):
    - inside while held -> ARMED.
    - release -> IDLE, no pulse.
  - HELD_OUT (3):
    - release -> IDLE.
    - Entering the rectangle does not arm.
- Simultaneous release and exit on the same cycle: the FSM uses the registered inside value from that cycle; no pulse unless inside = 1.
- enable low:
  - FSM forced to IDLE next edge; return_click = 0; hover flag = 0.
  - If enable rises while the button is already held: IDLE ignores a level with no press edge. The press-edge detector compares against the previous mouse_left_db, so there is no spurious arming.
- return_click is never asserted on two consecutive cycles.
- Reset mid-press: FSM returns to IDLE; mouse_left_db returns to 0.
  - If the raw button is still held, debouncing re-accepts it after DEBOUNCE_CYCLES. That appears as a press edge, which arms only if the cursor is inside.

Decomposition:
- Shared package `sudoku_ui_pkg`:
  - button-state enum (IDLE, ARMED, DRAGGED, HELD_OUT), 2-bit.
  - screen constants H_ACTIVE = 640, V_ACTIVE = 480.
  - return-button rectangle defaults, so the pixel generator and the sprite address map agree.
- One sub-module: `button_debouncer` (counter plus accepted level, parameter DEBOUNCE_CYCLES), reusable for the middle and right mouse buttons.

Test Plan (DEBOUNCE_CYCLES overridden to 4):
- Reset: rst = 1 for 2 cycles with MOUSE_LEFT = 1 -> all outputs 0, btn_state = 0; mouse_left_db rises exactly 4 cycles after rst falls.
- Edge hits: enable = 1; cursor at (256,352), (383,399), (255,352), (384,399), (256,400) -> hover flag 1, 1, 0, 0, 0, each one cycle after the input is applied.
- Valid click: cursor (300,370), press for 10 cycles, release -> btn_state goes 0->1 on the press; exactly one return_click pulse, 5 cycles after release (4 debounce + 1 FSM).
- Drag out and back: press at (300,370), move to (100,100) -> state 2; move back -> state 1; release -> one pulse. Repeat with release at (100,100) -> no pulse, state 0.
- Glitch and held-out: 3-cycle MOUSE_LEFT pulse inside -> mouse_left_db stays 0, no pulse. Press at (10,10), drag inside, release -> state 3 then 0, no pulse.
- Enable drop: in ARMED, enable = 0 for 1 cycle, then release inside -> state 0 after the drop; no pulse; hover flag 0 while disabled.

Source files
------------

// File: rtl/sudoku_ui_pkg.sv
// Shared UI definitions for the sudoku screens: screen size, return-button
// rectangle, button-tracker state encoding and a rectangle hit-test helper.
package sudoku_ui_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // Return-button rectangle, inclusive edges; the sprite address map uses the same values.
    localparam int unsigned RET_BTN_X0 = 256;
    localparam int unsigned RET_BTN_X1 = 383;
    localparam int unsigned RET_BTN_Y0 = 352;
    localparam int unsigned RET_BTN_Y1 = 399;

    localparam int DB_CNT_W = 20;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        DRAGGED  = 2'd2,
        HELD_OUT = 2'd3
    } btn_state_e;

    function automatic logic in_rect(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [9:0] x0,
        input logic [9:0] x1,
        input logic [9:0] y0,
        input logic [9:0] y1
    );
        return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
    endfunction

endpackage

// File: rtl/return_button_tracker_if.sv
// Mouse/button signal bundle between the cursor source and the return-button tracker.
interface return_button_tracker_if;

    logic       enable;
    logic [9:0] mouse_x;
    logic [9:0] mouse_y;
    logic       MOUSE_LEFT;
    logic       mouse_on_return_button;
    logic       mouse_left_db;
    logic       return_click;
    logic [1:0] btn_state;

    modport master (
        output enable, mouse_x, mouse_y, MOUSE_LEFT,
        input  mouse_on_return_button, mouse_left_db, return_click, btn_state
    );

    modport slave (
        input  enable, mouse_x, mouse_y, MOUSE_LEFT,
        output mouse_on_return_button, mouse_left_db, return_click, btn_state
    );

endinterface

// File: rtl/return_button_tracker_debouncer.sv
// Level debouncer: a new input level is accepted only after it has differed
// from the accepted level for DEBOUNCE_CYCLES consecutive cycles.
module button_debouncer
    import sudoku_ui_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic level_o
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_CNT_W-1:0] cnt_q, cnt_d;
    logic                level_q, level_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        cnt_d   = cnt_q;
        level_d = level_q;
        if (level_i == level_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
            level_d = level_i;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/return_button_tracker.sv
// Game-over return button: registered hover flag, debounced left button and a
// one-cycle click pulse for a press and release that both land inside the button.
module return_button_tracker
    import sudoku_ui_pkg::*;
#(
    parameter int unsigned BTN_X0          = RET_BTN_X0,
    parameter int unsigned BTN_X1          = RET_BTN_X1,
    parameter int unsigned BTN_Y0          = RET_BTN_Y0,
    parameter int unsigned BTN_Y1          = RET_BTN_Y1,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input logic                   clk,
    input logic                   rst,
    return_button_tracker_if.slave bus
);

    logic       hit;
    logic       left_db;
    logic       press_edge;
    logic       inside_q;
    logic       db_prev_q;
    logic       click_q;
    btn_state_e state_q;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_left_db (
        .clk    (clk),
        .rst    (rst),
        .level_i(bus.MOUSE_LEFT),
        .level_o(left_db)
    );

    assign hit = in_rect(bus.mouse_x, bus.mouse_y,
                         10'(BTN_X0), 10'(BTN_X1), 10'(BTN_Y0), 10'(BTN_Y1));

    // Edge against the previous accepted level, so a button already held when enable rises never arms.
    assign press_edge = left_db && !db_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            click_q   <= 1'b0;
            inside_q  <= 1'b0;
            db_prev_q <= 1'b0;
        end else begin
            inside_q  <= hit && bus.enable;
            db_prev_q <= left_db;
            click_q   <= 1'b0;
            if (!bus.enable) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (press_edge) state_q <= inside_q ? ARMED : HELD_OUT;
                    end
                    ARMED: begin
                        if (!left_db) begin
                            state_q <= IDLE;
                            click_q <= inside_q;
                        end else if (!inside_q) begin
                            state_q <= DRAGGED;
                        end
                    end
                    DRAGGED: begin
                        if (!left_db)     state_q <= IDLE;
                        else if (inside_q) state_q <= ARMED;
                    end
                    HELD_OUT: begin
                        if (!left_db) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.mouse_on_return_button = inside_q;
    assign bus.mouse_left_db          = left_db;
    assign bus.return_click           = click_q;
    assign bus.btn_state              = state_q;

endmodule

// File: tb/tb_return_button_tracker.sv
// Bench for return_button_tracker: directed plan steps plus a random phase,
// every cycle compared against a session-level reference model.
module tb_return_button_tracker;

    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   pulses = 0;

    always #5 clk = ~clk;

    return_button_tracker_if bus ();

    return_button_tracker #(
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference model: a press "session" remembers whether it began over the
    // button and whether the cursor was over it at the last evaluation.
    bit m_hover, m_db, m_db_prev, m_click, m_active, m_from_in, m_over;
    int m_run;

    function automatic bit on_button(int x, int y);
        return x >= 256 && x <= 383 && y >= 352 && y <= 399;
    endfunction

    function automatic int m_state();
        if (!m_active)  return 0;
        if (!m_from_in) return 3;
        return m_over ? 1 : 2;
    endfunction

    task automatic model_update();
        bit old_hover, old_db, raw, en;
        old_hover = m_hover;
        old_db    = m_db;
        raw       = bus.MOUSE_LEFT;
        en        = bus.enable;
        if (rst) begin
            m_hover = 0; m_db = 0; m_db_prev = 0; m_click = 0;
            m_active = 0; m_from_in = 0; m_over = 0; m_run = 0;
            return;
        end
        m_hover = on_button(int'(bus.mouse_x), int'(bus.mouse_y)) && en;
        if (raw != old_db) begin
            m_run++;
            if (m_run >= DC) begin
                m_db  = raw;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_click = 0;
        if (!en) begin
            m_active = 0;
        end else if (!m_active) begin
            if (old_db && !m_db_prev) begin
                m_active  = 1;
                m_from_in = old_hover;
                m_over    = old_hover;
            end
        end else if (!old_db) begin
            m_click  = m_from_in && m_over && old_hover;
            m_active = 0;
        end else if (m_from_in) begin
            m_over = old_hover;
        end
        m_db_prev = old_db;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check("model_hover", 32'(bus.mouse_on_return_button), 32'(m_hover));
        check("model_db",    32'(bus.mouse_left_db),          32'(m_db));
        check("model_click", 32'(bus.return_click),           32'(m_click));
        check("model_state", 32'(bus.btn_state),              32'(m_state()));
        if (bus.return_click) pulses++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cursor(input int x, input int y);
        bus.mouse_x = 10'(x);
        bus.mouse_y = 10'(y);
    endtask

    int hx[5] = '{256, 383, 255, 384, 256};
    int hy[5] = '{352, 399, 352, 399, 400};
    int he[5] = '{1, 1, 0, 0, 0};

    initial begin
        bus.enable     = 1'b0;
        bus.MOUSE_LEFT = 1'b1;
        cursor(0, 0);
        rst = 1'b1;

        // Reset with the raw button held
        steps(2);
        check("rst_hover", 32'(bus.mouse_on_return_button), 0);
        check("rst_db",    32'(bus.mouse_left_db), 0);
        check("rst_click", 32'(bus.return_click), 0);
        check("rst_state", 32'(bus.btn_state), 0);
        rst = 1'b0;
        steps(3);
        check("db_before_4", 32'(bus.mouse_left_db), 0);
        step();
        check("db_at_4", 32'(bus.mouse_left_db), 1);
        bus.MOUSE_LEFT = 1'b0;
        bus.enable     = 1'b1;
        steps(6);

        // Rectangle edges
        for (int i = 0; i < 5; i++) begin
            cursor(hx[i], hy[i]);
            step();
            check($sformatf("edge_hit%0d", i), 32'(bus.mouse_on_return_button), 32'(he[i]));
        end

        // Valid click
        cursor(300, 370);
        step();
        bus.MOUSE_LEFT = 1'b1;
        steps(4);
        check("click_state_pre", 32'(bus.btn_state), 0);
        step();
        check("click_armed", 32'(bus.btn_state), 1);
        steps(5);
        bus.MOUSE_LEFT = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("click_early", 32'(bus.return_click), 0);
        end
        step();
        check("click_at5", 32'(bus.return_click), 1);
        steps(3);
        check("click_count", 32'(pulses), 1);
        check("click_idle", 32'(bus.btn_state), 0);

        // Drag out and back, release inside
        bus.MOUSE_LEFT = 1'b1;
        steps(6);
        check("drag_armed", 32'(bus.btn_state), 1);
        cursor(100, 100);
        steps(2);
        check("drag_out", 32'(bus.btn_state), 2);
        cursor(300, 370);
        steps(2);
        check("drag_back", 32'(bus.btn_state), 1);
        bus.MOUSE_LEFT = 1'b0;
        pulses = 0;
        steps(8);
        check("drag_pulses", 32'(pulses), 1);
        check("drag_idle", 32'(bus.btn_state), 0);

        // Drag out, release outside
        bus.MOUSE_LEFT = 1'b1;
        steps(6);
        cursor(100, 100);
        steps(2);
        check("dragrel_out", 32'(bus.btn_state), 2);
        bus.MOUSE_LEFT = 1'b0;
        pulses = 0;
        steps(8);
        check("dragrel_pulses", 32'(pulses), 0);
        check("dragrel_idle", 32'(bus.btn_state), 0);

        // Short glitch inside
        cursor(300, 370);
        step();
        pulses = 0;
        bus.MOUSE_LEFT = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) bus.MOUSE_LEFT = 1'b0;
            step();
            check("glitch_db", 32'(bus.mouse_left_db), 0);
        end
        check("glitch_pulses", 32'(pulses), 0);

        // Press outside, drag in, release
        cursor(10, 10);
        step();
        bus.MOUSE_LEFT = 1'b1;
        steps(6);
        check("heldout", 32'(bus.btn_state), 3);
        cursor(300, 370);
        steps(3);
        check("heldout_in", 32'(bus.btn_state), 3);
        bus.MOUSE_LEFT = 1'b0;
        pulses = 0;
        steps(6);
        check("heldout_idle", 32'(bus.btn_state), 0);
        check("heldout_pulses", 32'(pulses), 0);

        // Enable drop while armed
        bus.MOUSE_LEFT = 1'b1;
        steps(6);
        check("en_armed", 32'(bus.btn_state), 1);
        bus.enable = 1'b0;
        step();
        check("en_drop_state", 32'(bus.btn_state), 0);
        check("en_drop_hover", 32'(bus.mouse_on_return_button), 0);
        bus.enable     = 1'b1;
        bus.MOUSE_LEFT = 1'b0;
        pulses = 0;
        steps(8);
        check("en_pulses", 32'(pulses), 0);
        check("en_idle", 32'(bus.btn_state), 0);

        // Random phase against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) bus.MOUSE_LEFT = ~bus.MOUSE_LEFT;
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 9) == 0) cursor($urandom_range(0, 639), $urandom_range(0, 479));
                else cursor($urandom_range(200, 440), $urandom_range(300, 450));
            end
            if ($urandom_range(0, 39) == 0) bus.enable = ~bus.enable;
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
